// File: rtl/clk_pkg.sv
// Shared types and phase constants for the PLL reset sequencer and its
// chipset clock-enable decode.
package clk_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_STABLE = 2'd1,
        S_ENABLE = 2'd2,
        S_RUN    = 2'd3
    } seq_state_t;

    localparam int         PHASE_W     = 4;
    localparam logic [1:0] CE28P_PHASE = 2'd0;
    localparam logic [1:0] CE28N_PHASE = 2'd2;
    localparam logic [3:0] CE7_PHASE   = 4'd0;
    localparam logic [3:0] PHASE_LAST  = 4'd15;

    // True when the registered phase is at the last slot of the 16-cycle frame.
    function automatic logic phase_is_last(input logic [PHASE_W-1:0] phase_v);
        return (phase_v == PHASE_LAST);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage single-bit synchroniser with asynchronous active-low reset,
// for bringing asynchronous status flags into the clk domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds system reset until the PLL lock has been stable long enough, then
// starts the phase-aligned 28/7 MHz enables and releases reset on a frame boundary.
module pll_reset_sequencer
    import clk_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int CNT_W              = $clog2(LOCK_STABLE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       sys_reset_n,
    output logic       ce_28p,
    output logic       ce_28n,
    output logic       ce_7,
    output logic [3:0] phase,
    output logic [1:0] seq_state,
    output logic       lock_lost
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic               locked_s;
    seq_state_t         state_r;
    seq_state_t         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [PHASE_W-1:0] phase_r;
    logic [PHASE_W-1:0] phase_nxt_s;
    logic               lock_lost_r;
    logic               lock_lost_nxt_s;
    logic               enables_on_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Sequencer state, stability counter, phase and sticky lock-loss registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_WAIT;
            cnt_r       <= '0;
            phase_r     <= '0;
            lock_lost_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            phase_r     <= phase_nxt_s;
            lock_lost_r <= lock_lost_nxt_s;
        end
    end

    // Next-state logic; a low locked_s overrides every other condition.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = '0;
        phase_nxt_s     = phase_r;
        lock_lost_nxt_s = lock_lost_r;

        if (soft_reset_req) begin
            lock_lost_nxt_s = 1'b0;
        end else begin
            lock_lost_nxt_s = lock_lost_r;
        end

        case (state_r)
            S_WAIT: begin
                phase_nxt_s = '0;
                if (locked_s) begin
                    state_nxt_s = S_STABLE;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_STABLE: begin
                phase_nxt_s = '0;
                if (!locked_s) begin
                    state_nxt_s = S_WAIT;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = S_ENABLE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            S_ENABLE: begin
                if (!locked_s) begin
                    state_nxt_s = S_WAIT;
                    phase_nxt_s = '0;
                end else begin
                    phase_nxt_s = phase_r + 4'd1;
                    if (phase_is_last(phase_r)) begin
                        state_nxt_s = S_RUN;
                    end else begin
                        state_nxt_s = S_ENABLE;
                    end
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_nxt_s     = S_WAIT;
                    phase_nxt_s     = '0;
                    lock_lost_nxt_s = 1'b1;
                end else begin
                    // Phase keeps running through a soft reset so the cadence never breaks.
                    phase_nxt_s = phase_r + 4'd1;
                    if (soft_reset_req) begin
                        state_nxt_s = S_ENABLE;
                    end else begin
                        state_nxt_s = S_RUN;
                    end
                end
            end
            default: begin
                state_nxt_s = S_WAIT;
                phase_nxt_s = '0;
            end
        endcase
    end

    assign enables_on_s = (state_r == S_ENABLE) || (state_r == S_RUN);

    assign sys_reset_n = (state_r == S_RUN);
    assign ce_28p      = enables_on_s && (phase_r[1:0] == CE28P_PHASE);
    assign ce_28n      = enables_on_s && (phase_r[1:0] == CE28N_PHASE);
    assign ce_7        = enables_on_s && (phase_r == CE7_PHASE);
    assign phase       = phase_r;
    assign seq_state   = state_r;
    assign lock_lost   = lock_lost_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised and directed bench for pll_reset_sequencer; expected behaviour comes
// from a run-length model of how long the synchronised lock has been high.
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int L    = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       sys_reset_n;
    logic       ce_28p;
    logic       ce_28n;
    logic       ce_7;
    logic [3:0] phase;
    logic [1:0] seq_state;
    logic       lock_lost;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: lock history, consecutive edges with locked_s high, soft-reset hold, sticky flag.
    bit m_hist[SYNC];
    int m_up;
    bit m_hold;
    bit m_ll;

    pll_reset_sequencer #(
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (L)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .sys_reset_n    (sys_reset_n),
        .ce_28p         (ce_28p),
        .ce_28n         (ce_28n),
        .ce_7           (ce_7),
        .phase          (phase),
        .seq_state      (seq_state),
        .lock_lost      (lock_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 wait, 1 stable, 2 enable, 3 run, derived purely from the lock run length.
    function automatic int m_state();
        if (m_up == 0)                    return 0;
        if (m_up <= L)                    return 1;
        if (m_up <= L + 16 || m_hold)     return 2;
        return 3;
    endfunction

    function automatic int m_phase();
        if (m_up <= L) return 0;
        return (m_up - L - 1) % 16;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
        m_up   = 0;
        m_hold = 1'b0;
        m_ll   = 1'b0;
    endtask

    task automatic model_edge(input bit lk, input bit req);
        int pre;
        int pph;
        bit ls;
        pre = m_state();
        pph = m_phase();
        ls  = m_hist[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = lk;
        if (!ls) begin
            if (pre == 3)      m_ll = 1'b1;
            else if (req)      m_ll = 1'b0;
            m_up   = 0;
            m_hold = 1'b0;
        end else begin
            if (req) m_ll = 1'b0;
            if (pre == 3 && req)            m_hold = 1'b1;
            else if (m_hold && pph == 15)   m_hold = 1'b0;
            m_up++;
        end
    endtask

    task automatic check_all(input string tag);
        int st;
        int ph;
        bit en;
        st = m_state();
        ph = m_phase();
        en = (st >= 2);
        check({tag, ".sys_reset_n"}, 32'(sys_reset_n), 32'(st == 3));
        check({tag, ".seq_state"},   32'(seq_state),   32'(st));
        check({tag, ".phase"},       32'(phase),       32'(ph));
        check({tag, ".ce_28p"},      32'(ce_28p),      32'(en && (ph % 4) == 0));
        check({tag, ".ce_28n"},      32'(ce_28n),      32'(en && (ph % 4) == 2));
        check({tag, ".ce_7"},        32'(ce_7),        32'(en && ph == 0));
        check({tag, ".lock_lost"},   32'(lock_lost),   32'(m_ll));
        if (ce_7) check({tag, ".ce7_in_ce28p"}, 32'(ce_28p), 32'd1);
    endtask

    task automatic step(input bit lk, input bit req, input string tag);
        pll_locked     = lk;
        soft_reset_req = req;
        @(posedge clk);
        model_edge(lk, req);
        #1;
        check_all(tag);
    endtask

    // Hold lock high from a fresh start and measure release and first-enable timing.
    task automatic wait_release(input string tag);
        int  n_rel;
        int  n_ce;
        bit  seen;
        n_rel = 0;
        n_ce  = 0;
        seen  = 1'b0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            step(1'b1, 1'b0, tag);
            if (ce_28p && n_ce == 0) n_ce = i;
            if (sys_reset_n) begin
                seen  = 1'b1;
                n_rel = i;
            end
        end
        check({tag, ".release_edges"}, 32'(n_rel), 32'd27);
        check({tag, ".first_ce28p"},   32'(n_ce),  32'd11);
        check({tag, ".rel_phase"},     32'(phase), 32'd0);
        check({tag, ".rel_ce7"},       32'(ce_7),  32'd1);
    endtask

    initial begin
        bit cur_lk;
        int n;
        bit seen;

        rst_n          = 1'b0;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        repeat (50) step(1'b0, 1'b0, "powerup");

        wait_release("clean");
        repeat (40) step(1'b1, 1'b0, "run");

        // Lock loss while running.
        n    = 0;
        seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, "loss");
            if (!seen && !sys_reset_n && !ce_28p && !ce_28n && !ce_7) begin
                seen = 1'b1;
                n    = i;
            end
        end
        check("loss_edges_in_2_3", 32'(n >= 2 && n <= 3), 32'd1);
        check("loss_sticky", 32'(lock_lost), 32'd1);

        // Glitch after five stable-counter cycles restarts the whole wait.
        repeat (7) step(1'b1, 1'b0, "pre_glitch");
        check("glitch_in_stable", 32'(seq_state), 32'd1);
        step(1'b0, 1'b0, "glitch");
        wait_release("relock");
        check("relock_sticky", 32'(lock_lost), 32'd1);

        // Soft reset while running at phase 5.
        for (int i = 0; i < 40 && !(phase == 4'd5 && seq_state == 2'd3); i++) begin
            step(1'b1, 1'b0, "to_ph5");
        end
        check("soft_at_ph5", 32'(phase), 32'd5);
        step(1'b1, 1'b1, "soft");
        check("soft_holds_reset", 32'(sys_reset_n), 32'd0);
        n    = 0;
        seen = 1'b0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            step(1'b1, 1'b0, "soft_hold");
            if (sys_reset_n) begin
                seen = 1'b1;
                n    = i;
            end
        end
        check("soft_release_edges", 32'(n), 32'd10);
        check("soft_release_phase", 32'(phase), 32'd0);
        check("soft_clears_sticky", 32'(lock_lost), 32'd0);

        // Asynchronous reset in the middle of the enable phase.
        repeat (5) step(1'b0, 1'b0, "drop");
        for (int i = 0; i < 30 && !(seq_state == 2'd2 && phase == 4'd3); i++) begin
            step(1'b1, 1'b0, "to_enable");
        end
        check("in_enable", 32'(seq_state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        rst_n = 1'b1;
        wait_release("after_async");

        // Randomised lock drops and soft-reset requests.
        cur_lk = 1'b1;
        for (int i = 0; i < 900; i++) begin
            if (cur_lk) cur_lk = ($urandom_range(0, 89) != 0);
            else        cur_lk = ($urandom_range(0, 2) == 0);
            step(cur_lk, ($urandom_range(0, 19) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
